// File: rtl/mpsoc_uart_irq_ctrl.sv
// 16550-style UART interrupt controller: tracks pending sources, masks them with IER
// and registers the prioritised interrupt ID (IIR) and the interrupt line.
module mpsoc_uart_irq_ctrl #(
    parameter int TX_FIFO_DEPTH = 32,
    parameter int RX_FIFO_DEPTH = 32,
    parameter int CTI_CHARS     = 4
) (
    input  logic                               clk_i,
    input  logic                               rstn_i,
    input  logic [3:0]                         IER_i,
    input  logic                               error_i,
    input  logic                               msr_change_i,
    input  logic                               char_tick_i,
    input  logic                               rx_push_i,
    input  logic [$clog2(RX_FIFO_DEPTH):0]     rx_elements_i,
    input  logic [$clog2(TX_FIFO_DEPTH):0]     tx_elements_i,
    input  logic [1:0]                         trigger_level_i,
    input  logic                               rbr_rd_i,
    input  logic                               thr_wr_i,
    input  logic                               iir_rd_i,
    input  logic                               lsr_rd_i,
    input  logic                               msr_rd_i,
    output logic                               interrupt_o,
    output logic [3:0]                         IIR_o
);

    localparam int RXW = $clog2(RX_FIFO_DEPTH) + 1;
    localparam logic [RXW-1:0] RX_TH_ONE  = RXW'(1);
    localparam logic [RXW-1:0] RX_TH_QTR  = RXW'(RX_FIFO_DEPTH / 4);
    localparam logic [RXW-1:0] RX_TH_HALF = RXW'(RX_FIFO_DEPTH / 2);
    localparam logic [RXW-1:0] RX_TH_FULL = RXW'(RX_FIFO_DEPTH - 2);
    localparam logic [3:0]     CTI_MAX    = 4'(CTI_CHARS);

    localparam logic [3:0] IIR_RLS  = 4'b0110;
    localparam logic [3:0] IIR_RDA  = 4'b0100;
    localparam logic [3:0] IIR_CTI  = 4'b1100;
    localparam logic [3:0] IIR_THRE = 4'b0010;
    localparam logic [3:0] IIR_MSI  = 4'b0000;
    localparam logic [3:0] IIR_NONE = 4'b0001;

    logic [RXW-1:0] w_rx_thresh;
    logic           w_rda_level;
    logic           w_rx_empty;
    logic           w_tx_empty;
    logic           w_cti_clr;
    logic           w_thre_set;
    logic           w_thre_clr;
    logic [3:0]     w_iir_next;

    logic           r_rls_pend;
    logic           r_msi_pend;
    logic           r_thre_pend;
    logic           r_cti_pend;
    logic [3:0]     r_cti_cnt;
    logic           r_tx_empty_prev;
    logic           r_ier1_prev;

    always_comb begin
        w_rx_thresh = RX_TH_ONE;
        case (trigger_level_i)
            2'b00:   w_rx_thresh = RX_TH_ONE;
            2'b01:   w_rx_thresh = RX_TH_QTR;
            2'b10:   w_rx_thresh = RX_TH_HALF;
            default: w_rx_thresh = RX_TH_FULL;
        endcase
    end

    assign w_rda_level = (rx_elements_i >= w_rx_thresh);
    assign w_rx_empty  = (rx_elements_i == '0);
    assign w_tx_empty  = (tx_elements_i == '0);
    assign w_cti_clr   = rx_push_i | rbr_rd_i | w_rx_empty;

    // THRE fires on the empty edge or on enabling THRE while already empty
    assign w_thre_set = (w_tx_empty & ~r_tx_empty_prev) | (IER_i[1] & ~r_ier1_prev & w_tx_empty);
    // IIR-read clear uses the currently presented ID, not the one being computed
    assign w_thre_clr = thr_wr_i | (iir_rd_i & (IIR_o == IIR_THRE));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_rls_pend      <= 1'b0;
            r_msi_pend      <= 1'b0;
            r_thre_pend     <= 1'b0;
            r_cti_pend      <= 1'b0;
            r_cti_cnt       <= 4'd0;
            r_tx_empty_prev <= 1'b1;
            r_ier1_prev     <= 1'b0;
        end else begin
            r_tx_empty_prev <= w_tx_empty;
            r_ier1_prev     <= IER_i[1];

            if (error_i)          r_rls_pend <= 1'b1;
            else if (lsr_rd_i)    r_rls_pend <= 1'b0;

            if (msr_change_i)     r_msi_pend <= 1'b1;
            else if (msr_rd_i)    r_msi_pend <= 1'b0;

            if (w_thre_set)       r_thre_pend <= 1'b1;
            else if (w_thre_clr)  r_thre_pend <= 1'b0;

            if (w_cti_clr)                               r_cti_cnt <= 4'd0;
            else if (char_tick_i && r_cti_cnt != CTI_MAX) r_cti_cnt <= r_cti_cnt + 4'd1;

            if (w_cti_clr)                 r_cti_pend <= 1'b0;
            else if (r_cti_cnt == CTI_MAX) r_cti_pend <= 1'b1;
        end
    end

    always_comb begin
        w_iir_next = IIR_NONE;
        if (IER_i[2] && r_rls_pend)       w_iir_next = IIR_RLS;
        else if (IER_i[0] && w_rda_level) w_iir_next = IIR_RDA;
        else if (IER_i[0] && r_cti_pend)  w_iir_next = IIR_CTI;
        else if (IER_i[1] && r_thre_pend) w_iir_next = IIR_THRE;
        else if (IER_i[3] && r_msi_pend)  w_iir_next = IIR_MSI;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            IIR_o       <= IIR_NONE;
            interrupt_o <= 1'b0;
        end else begin
            IIR_o       <= w_iir_next;
            interrupt_o <= ~w_iir_next[0];
        end
    end

endmodule

// File: tb/tb_mpsoc_uart_irq_ctrl.sv
// Directed bench for mpsoc_uart_irq_ctrl: stimulus queues each expected IIR change,
// a monitor pops and checks whenever IIR_o changes.
module tb_mpsoc_uart_irq_ctrl;

    logic       clk_i = 1'b0;
    logic       rstn_i;
    logic [3:0] IER_i;
    logic       error_i, msr_change_i, char_tick_i, rx_push_i;
    logic [5:0] rx_elements_i;
    logic [5:0] tx_elements_i;
    logic [1:0] trigger_level_i;
    logic       rbr_rd_i, thr_wr_i, iir_rd_i, lsr_rd_i, msr_rd_i;
    logic       interrupt_o;
    logic [3:0] IIR_o;

    logic [3:0] exp_q[$];
    int         total = 0;
    int         bad   = 0;

    mpsoc_uart_irq_ctrl #(
        .TX_FIFO_DEPTH(32),
        .RX_FIFO_DEPTH(32),
        .CTI_CHARS    (4)
    ) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .IER_i          (IER_i),
        .error_i        (error_i),
        .msr_change_i   (msr_change_i),
        .char_tick_i    (char_tick_i),
        .rx_push_i      (rx_push_i),
        .rx_elements_i  (rx_elements_i),
        .tx_elements_i  (tx_elements_i),
        .trigger_level_i(trigger_level_i),
        .rbr_rd_i       (rbr_rd_i),
        .thr_wr_i       (thr_wr_i),
        .iir_rd_i       (iir_rd_i),
        .lsr_rd_i       (lsr_rd_i),
        .msr_rd_i       (msr_rd_i),
        .interrupt_o    (interrupt_o),
        .IIR_o          (IIR_o)
    );

    always #5 clk_i = ~clk_i;

    // Monitor: every change of IIR_o must match the next queued expectation
    initial begin : monitor
        logic [3:0] prev;
        logic [3:0] e;
        prev = 4'hF;
        forever begin
            @(negedge clk_i);
            if (IIR_o !== prev) begin
                prev = IIR_o;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_iir_change got=%b want=no_change t=%0t", IIR_o, $time);
                end else begin
                    e = exp_q.pop_front();
                    total++;
                    if (IIR_o !== e) begin
                        bad++;
                        $display("FAIL iir got=%b want=%b t=%0t", IIR_o, e, $time);
                    end
                    total++;
                    if (interrupt_o !== ~e[0]) begin
                        bad++;
                        $display("FAIL interrupt got=%b want=%b t=%0t", interrupt_o, ~e[0], $time);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog_timeout got=running want=finished");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic expect_iir(input logic [3:0] v);
        exp_q.push_back(v);
    endtask

    task automatic tick();
        char_tick_i = 1'b1;
        cyc(1);
        char_tick_i = 1'b0;
        cyc(1);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin : stim
        rstn_i = 1'b0;
        IER_i = 4'b0000;
        error_i = 1'b0; msr_change_i = 1'b0; char_tick_i = 1'b0; rx_push_i = 1'b0;
        rx_elements_i = 6'd0; tx_elements_i = 6'd0; trigger_level_i = 2'b00;
        rbr_rd_i = 1'b0; thr_wr_i = 1'b0; iir_rd_i = 1'b0; lsr_rd_i = 1'b0; msr_rd_i = 1'b0;
        expect_iir(4'b0001);
        cyc(3);
        rstn_i = 1'b1;
        cyc(4);

        // RDA level at half-full trigger
        trigger_level_i = 2'b10; IER_i = 4'b0001; rx_elements_i = 6'd15; cyc(4);
        expect_iir(4'b0100); rx_elements_i = 6'd16; cyc(4);
        expect_iir(4'b0001); rx_elements_i = 6'd15; cyc(4);
        rx_elements_i = 6'd0; cyc(2);
        // Remaining trigger thresholds at their boundaries
        trigger_level_i = 2'b00; cyc(2);
        expect_iir(4'b0100); rx_elements_i = 6'd1; cyc(4);
        expect_iir(4'b0001); rx_elements_i = 6'd0; cyc(4);
        trigger_level_i = 2'b01; rx_elements_i = 6'd7; cyc(4);
        expect_iir(4'b0100); rx_elements_i = 6'd8; cyc(4);
        expect_iir(4'b0001); rx_elements_i = 6'd0; cyc(4);
        trigger_level_i = 2'b11; rx_elements_i = 6'd29; cyc(4);
        expect_iir(4'b0100); rx_elements_i = 6'd30; cyc(4);
        expect_iir(4'b0001); rx_elements_i = 6'd0; cyc(4);

        // RLS above RDA, and set beating clear
        IER_i = 4'b0101; trigger_level_i = 2'b00;
        expect_iir(4'b0100); rx_elements_i = 6'd1; cyc(4);
        expect_iir(4'b0110); error_i = 1'b1; cyc(1); error_i = 1'b0; cyc(4);
        expect_iir(4'b0100); lsr_rd_i = 1'b1; cyc(1); lsr_rd_i = 1'b0; cyc(4);
        expect_iir(4'b0001); rx_elements_i = 6'd0; cyc(4);
        expect_iir(4'b0110); error_i = 1'b1; lsr_rd_i = 1'b1; cyc(1);
        error_i = 1'b0; lsr_rd_i = 1'b0; cyc(4);
        expect_iir(4'b0001); lsr_rd_i = 1'b1; cyc(1); lsr_rd_i = 1'b0; cyc(4);

        // Character timeout: saturation, clears by read and push
        IER_i = 4'b0001; trigger_level_i = 2'b11; rx_elements_i = 6'd3; cyc(2);
        ticks(3); cyc(3);
        expect_iir(4'b1100); tick(); cyc(4);
        expect_iir(4'b0001); rbr_rd_i = 1'b1; cyc(1); rbr_rd_i = 1'b0; cyc(2);
        ticks(3); cyc(2);
        rx_push_i = 1'b1; cyc(1); rx_push_i = 1'b0;
        ticks(3); cyc(3);
        expect_iir(4'b1100); tick(); cyc(4);
        expect_iir(4'b0001); rx_elements_i = 6'd0; cyc(4);

        // THRE: empty edge, IIR-read clear, coincident write, IER rise
        IER_i = 4'b0000; tx_elements_i = 6'd1; cyc(2);
        IER_i = 4'b0010; cyc(4);
        expect_iir(4'b0010); tx_elements_i = 6'd0; cyc(4);
        expect_iir(4'b0001); iir_rd_i = 1'b1; cyc(1); iir_rd_i = 1'b0; cyc(4);
        tx_elements_i = 6'd1; cyc(2);
        expect_iir(4'b0010); tx_elements_i = 6'd0; thr_wr_i = 1'b1; cyc(1); thr_wr_i = 1'b0; cyc(4);
        expect_iir(4'b0001); thr_wr_i = 1'b1; cyc(1); thr_wr_i = 1'b0; cyc(4);
        IER_i = 4'b0000; cyc(2);
        expect_iir(4'b0010); IER_i = 4'b0010; cyc(4);
        expect_iir(4'b0001); thr_wr_i = 1'b1; cyc(1); thr_wr_i = 1'b0; cyc(4);
        // IIR read while RLS is presented must not clear THRE
        IER_i = 4'b0110; tx_elements_i = 6'd1; cyc(2);
        expect_iir(4'b0010); tx_elements_i = 6'd0; cyc(4);
        expect_iir(4'b0110); error_i = 1'b1; cyc(1); error_i = 1'b0; cyc(4);
        iir_rd_i = 1'b1; cyc(1); iir_rd_i = 1'b0; cyc(4);
        expect_iir(4'b0010); lsr_rd_i = 1'b1; cyc(1); lsr_rd_i = 1'b0; cyc(4);
        expect_iir(4'b0001); thr_wr_i = 1'b1; cyc(1); thr_wr_i = 1'b0; cyc(4);

        // MSI with RLS masked, then unmasked
        IER_i = 4'b1000; cyc(2);
        expect_iir(4'b0000); msr_change_i = 1'b1; error_i = 1'b1; cyc(1);
        msr_change_i = 1'b0; error_i = 1'b0; cyc(4);
        expect_iir(4'b0110); IER_i = 4'b1100; cyc(4);
        expect_iir(4'b0000); lsr_rd_i = 1'b1; cyc(1); lsr_rd_i = 1'b0; cyc(4);
        expect_iir(4'b0001); msr_rd_i = 1'b1; cyc(1); msr_rd_i = 1'b0; cyc(4);
        expect_iir(4'b0000); msr_change_i = 1'b1; msr_rd_i = 1'b1; cyc(1);
        msr_change_i = 1'b0; msr_rd_i = 1'b0; cyc(4);
        expect_iir(4'b0001); msr_rd_i = 1'b1; cyc(1); msr_rd_i = 1'b0; cyc(4);

        // Mid-operation reset with THRE and CTI pending
        tx_elements_i = 6'd1; cyc(2);
        IER_i = 4'b0011; cyc(2);
        expect_iir(4'b0010); tx_elements_i = 6'd0; cyc(4);
        rx_elements_i = 6'd3; cyc(2);
        ticks(3); cyc(2);
        expect_iir(4'b1100); tick(); cyc(4);
        expect_iir(4'b0001);
        rstn_i = 1'b0; tx_elements_i = 6'd2;
        cyc(1);
        rstn_i = 1'b1;
        cyc(8);
        ticks(3); cyc(3);
        expect_iir(4'b1100); tick(); cyc(4);
        tx_elements_i = 6'd0; cyc(4);
        expect_iir(4'b0010); rbr_rd_i = 1'b1; cyc(1); rbr_rd_i = 1'b0; cyc(4);
        expect_iir(4'b0001); thr_wr_i = 1'b1; cyc(1); thr_wr_i = 1'b0; cyc(4);

        cyc(10);
        while (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL missing_iir_change got=none want=%b", exp_q.pop_front());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mpsoc_uart_irq_ctrl.md
MPSOC_UART_IRQ_CTRL -- requirements
Module: mpsoc_uart_irq_ctrl

Interface
REQ-001 SHALL have parameter TX_FIFO_DEPTH, default 32; TX FIFO depth, power of 2, >= 4.
REQ-002 SHALL have parameter RX_FIFO_DEPTH, default 32; RX FIFO depth, power of 2, >= 4.
REQ-003 SHALL have parameter CTI_CHARS, default 4; character times before character-timeout, range 1..15.
REQ-004 SHALL have port clk_i, input, 1 bit; single clock.
REQ-005 SHALL have port rstn_i, input, 1 bit; asynchronous, active-low reset.
REQ-006 SHALL have port IER_i, input, 4 bits; enables: [0] RDA/CTI, [1] THRE, [2] RLS, [3] MSI.
REQ-007 SHALL have ports error_i (1; line-status error pulse), msr_change_i (1; modem-status change pulse) and char_tick_i (1; one pulse per character time), all inputs.
REQ-008 SHALL have inputs rx_push_i (1; RX FIFO write) and rx_elements_i ($clog2(RX_FIFO_DEPTH)+1 bits; RX fill level).
REQ-009 SHALL have inputs tx_elements_i ($clog2(TX_FIFO_DEPTH)+1 bits; TX fill level) and trigger_level_i (2 bits; RX trigger select).
REQ-010 SHALL have read/write strobes rbr_rd_i, thr_wr_i, iir_rd_i, lsr_rd_i and msr_rd_i, all inputs, 1 bit, 1-cycle pulses.
REQ-011 SHALL have outputs interrupt_o (1 bit; registered, active-high) and IIR_o (4 bits; registered 16550 interrupt ID).

Function
REQ-012 SHALL decode RX trigger thresholds as 00 -> 1, 01 -> RX_FIFO_DEPTH/4, 10 -> RX_FIFO_DEPTH/2, 11 -> RX_FIFO_DEPTH-2.
REQ-013 SHALL assert rda_level when rx_elements_i >= threshold, as an unsigned compare; rda_level is combinational and level-based, not a pending bit.
REQ-014 SHALL set RLS pending on error_i; lsr_rd_i SHALL clear it; set wins over clear in the same cycle.
REQ-015 SHALL set MSI pending on msr_change_i; msr_rd_i SHALL clear it; set wins over clear in the same cycle.
REQ-016 SHALL set THRE pending on tx_elements_i transitioning from nonzero to 0, or on IER_i[1] rising while tx_elements_i == 0.
REQ-017 SHALL clear THRE pending on thr_wr_i, or on iir_rd_i when IIR_o currently reads 0010; a set in the same cycle wins.
REQ-018 SHALL keep a CTI counter, 4 bits, that increments on char_tick_i and saturates at CTI_CHARS.
REQ-019 SHALL clear the CTI counter to 0 on rx_push_i, on rbr_rd_i, or when rx_elements_i == 0; clear has priority over increment.
REQ-020 SHALL set CTI pending when the counter reaches CTI_CHARS and rx_elements_i != 0; rbr_rd_i, rx_push_i or rx_elements_i == 0 SHALL clear it.
REQ-021 SHALL qualify each source by its IER_i bit before priority encoding; a disabled source SHALL keep its pending bit but not report it.
REQ-022 SHALL encode priority, highest first: RLS -> 0110, RDA (rda_level) -> 0100, CTI -> 1100, THRE -> 0010, MSI -> 0000; no qualified source -> 0001.
REQ-023 SHALL register IIR_o from the encoder output, giving 1-cycle latency from pending or level change to IIR_o.
REQ-024 SHALL drive interrupt_o = ~IIR_o[0], registered in the same cycle as IIR_o.
REQ-025 SHALL evaluate the iir_rd_i THRE clear against the pre-update IIR_o value, not the next-state encoder output.
REQ-026 SHALL count rx/tx element values saturated at depth as legal; values above depth are out of range and produce unspecified output.

Reset
REQ-027 SHALL, while rstn_i is low, asynchronously force all pending bits to 0, the CTI counter to 0, IIR_o to 0001 and interrupt_o to 0.
REQ-028 SHALL reset the internal previous-state registers for tx-empty and IER_i[1] to 1 and 0 respectively, so an empty TX FIFO after reset raises no THRE until IER_i[1] rises.
REQ-029 SHALL, when reset is asserted mid-operation, lose all pending interrupts; no source SHALL re-raise until a new qualifying event occurs, except level-based RDA.

Verification
REQ-030 SHALL be verified by this scenario: depth 32, trigger 10, IER=0001, rx_elements 15 -> 16 -> IIR_o=0100 and interrupt_o=1 one cycle later; drop to 15 -> IIR_o=0001.
REQ-031 SHALL be verified by this scenario: RDA and RLS pending together, IER=0101 -> IIR_o=0110; lsr_rd_i -> IIR_o=0100 next cycle.
REQ-032 SHALL be verified by this scenario: rx_elements=3, trigger 11, IER=0001, 4 char_tick_i pulses with no push or read -> IIR_o=1100; rbr_rd_i -> 0001.
REQ-033 SHALL be verified by this scenario: IER=0010, tx_elements 1 -> 0 -> IIR_o=0010; iir_rd_i -> 0001; a thr_wr_i coincident with a new empty edge -> THRE stays pending.
REQ-034 SHALL be verified by this scenario: msr_change_i and error_i pulse with IER=1000 -> IIR_o=0000 (MSI only, RLS masked); set IER[2] -> IIR_o=0110.
REQ-035 SHALL be verified by this scenario: rstn_i low for 1 cycle while THRE and CTI are pending -> IIR_o=0001, interrupt_o=0 immediately, and both stay cleared after release.
